// File: rtl/ram_arb_pkg.sv
// Shared encodings and RAM geometry for the RAM port arbiter.
package ram_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  localparam int RAM_AW    = 6;
  localparam int RAM_DW    = 8;
  localparam int RAM_DEPTH = 64;
endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Round-robin picker: first requester set at or after ptr+1 (mod NREQ).
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   grant,
  output logic            anyReq
);
  always_comb begin
    grant  = '0;
    anyReq = |req;
    // Walk backwards so the nearest candidate after ptr is the last assignment.
    for (int i = NREQ; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) grant = PW'((int'(ptr) + i) % NREQ);
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM between NREQ requesters with round-robin grants and a clear sequencer.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = RAM_AW,
  parameter int DW   = RAM_DW
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  ack,
  output logic [DW-1:0]    rdata,
  input  logic             clear_req,
  output logic             clear_done,
  output logic             busy,
  output logic [AW-1:0]    ram_readAddress,
  output logic [AW-1:0]    ram_writeAddress,
  output logic [DW-1:0]    ram_WriteData,
  output logic             ram_writeEn,
  output logic             ram_readEn,
  output logic             ram_Reset,
  input  logic [DW-1:0]    ram_ReadData
);
  localparam int PW = $clog2(NREQ);

  state_t          state, stateNxt;
  logic            clrFlag;
  logic [PW-1:0]   ptr, gReg, gNxt;
  logic            weReg;
  logic [AW-1:0]   addrReg;
  logic [DW-1:0]   wdataReg;
  logic            anyReq;
  logic            accessLive;

  rr_pick #(.NREQ(NREQ), .PW(PW)) uPick (
    .req    (req),
    .ptr    (ptr),
    .grant  (gNxt),
    .anyReq (anyReq)
  );

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (clear_req) stateNxt = CLEAR;
               else if (anyReq) stateNxt = ACCESS;
      ACCESS:  stateNxt = DONE;
      DONE:    stateNxt = IDLE;
      CLEAR:   stateNxt = DONE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      clrFlag  <= 1'b0;
      ptr      <= '0;
      gReg     <= '0;
      weReg    <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      rdata    <= '0;
    end else begin
      state <= stateNxt;
      if (state == IDLE && !clear_req && anyReq) begin
        gReg     <= gNxt;
        weReg    <= we[gNxt];
        addrReg  <= addr[gNxt*AW +: AW];
        wdataReg <= wdata[gNxt*DW +: DW];
      end
      if (state == ACCESS) begin
        ptr     <= gReg;
        clrFlag <= 1'b0;
        if (!weReg) rdata <= ram_ReadData;
      end
      if (state == CLEAR) clrFlag <= 1'b1;
    end
  end

  // Reset kills the RAM strobes in the same cycle so an in-flight write is dropped.
  assign accessLive = (state == ACCESS) && !Reset;

  always_comb begin
    ack              = '0;
    clear_done       = 1'b0;
    busy             = (state != IDLE);
    ram_writeEn      = accessLive && weReg;
    ram_readEn       = accessLive && !weReg;
    ram_writeAddress = ram_writeEn ? addrReg : '0;
    ram_WriteData    = ram_writeEn ? wdataReg : '0;
    ram_readAddress  = ram_readEn ? addrReg : '0;
    ram_Reset        = (state == CLEAR) && !Reset;
    if (state == DONE) begin
      if (clrFlag) clear_done = 1'b1;
      else         ack[gReg]  = 1'b1;
    end
  end
endmodule
